// File: rtl/decode_issue_queue.sv
// decode_issue_queue
//   Decode/issue stage: DEPTH-entry FIFO of fetched instructions, head decode,
//   operand resolution from the register file or NFWD forwarding sources,
//   load-use hazard hold, and a registered valid/ready output stage.
// Ports
//   clk, reset           clock, synchronous active-high reset
//   flush                drop all queued and output-stage entries
//   in_valid/in_ready    fetch handshake; in_pc, in_instr, in_err payload
//   ra1, ra2             register-file read addresses from the head entry
//   rd1, rd2             register-file read data (combinational)
//   fwd_valid/dst/pending/data  forwarding sources, index 0 highest priority
//   stall_hazard         head is valid but held by a pending source
//   out_valid/out_ready  execute handshake; out_* decoded payload
module decode_issue_queue #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned NFWD  = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [63:0]            in_pc,
   input  logic [31:0]            in_instr,
   input  logic [1:0]             in_err,
   output logic [4:0]             ra1,
   output logic [4:0]             ra2,
   input  logic [XLEN-1:0]        rd1,
   input  logic [XLEN-1:0]        rd2,
   input  logic [NFWD-1:0]        fwd_valid,
   input  logic [NFWD*5-1:0]      fwd_dst,
   input  logic [NFWD-1:0]        fwd_pending,
   input  logic [NFWD*XLEN-1:0]   fwd_data,
   output logic                   stall_hazard,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [63:0]            out_pc,
   output logic [31:0]            out_instr,
   output logic [4:0]             out_dst,
   output logic [XLEN-1:0]        out_src1,
   output logic [XLEN-1:0]        out_src2,
   output logic [1:0]             out_err
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      logic [1:0]  err;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   logic            out_valid_q, out_valid_d;
   logic [63:0]     out_pc_q, out_pc_d;
   logic [31:0]     out_instr_q, out_instr_d;
   logic [4:0]      out_dst_q, out_dst_d;
   logic [XLEN-1:0] out_src1_q, out_src1_d, out_src2_q, out_src2_d;
   logic [1:0]      out_err_q, out_err_d;

   entry_t          head;
   logic [6:0]      opcode;
   logic            head_valid, push, pop, hazard;
   logic            use1, use2, haz1, haz2, legal;
   logic [XLEN-1:0] src1, src2;
   logic [1:0]      err_code;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(DEPTH - 1)) return '0;
      return p + 1'b1;
   endfunction

   // Returns {hazard, value}. Scanning from the oldest source down lets the
   // lowest matching index overwrite, so the youngest producer wins.
   function automatic logic [XLEN:0] resolve(input logic [4:0] ra, input logic [XLEN-1:0] rf);
      logic [XLEN:0] r;
      r = {1'b0, rf};
      for (int i = int'(NFWD) - 1; i >= 0; i--) begin
         if (fwd_valid[i] && (fwd_dst[i*5 +: 5] == ra)) begin
            r = {fwd_pending[i], fwd_data[i*XLEN +: XLEN]};
         end
      end
      if (ra == 5'd0) r = '0;
      return r;
   endfunction

   assign head       = mem_q[rd_ptr_q];
   assign head_valid = (count_q != '0);
   assign opcode     = head.instr[6:0];
   assign ra1        = head.instr[19:15];
   assign ra2        = head.instr[24:20];
   assign in_ready   = (count_q < CntW'(DEPTH));

   always_comb begin
      use1 = 1'b1;
      use2 = 1'b0;
      legal = 1'b0;
      case (opcode)
         7'b0110111, 7'b0010111, 7'b1101111: use1 = 1'b0;
         default: ;
      endcase
      case (opcode)
         7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011: use2 = 1'b1;
         default: ;
      endcase
      case (opcode)
         7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011, 7'b0000011, 7'b0100011,
         7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011:
            legal = 1'b1;
         default: ;
      endcase

      {haz1, src1} = resolve(ra1, rd1);
      {haz2, src2} = resolve(ra2, rd2);

      if (head.err != 2'd0) err_code = head.err;
      else if (!legal)      err_code = 2'd3;
      else                  err_code = 2'd0;

      // Faulting entries never wait on operands; execute only reports them.
      hazard       = (err_code == 2'd0) && ((use1 && haz1) || (use2 && haz2));
      stall_hazard = head_valid && hazard && !flush;
      pop          = head_valid && !hazard && (!out_valid_q || out_ready) && !flush;
      push         = in_valid && in_ready && !flush;
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = '{pc: in_pc, instr: in_instr, err: in_err};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + CntW'(push) - CntW'(pop);
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_pc_d    = out_pc_q;
      out_instr_d = out_instr_q;
      out_dst_d   = out_dst_q;
      out_src1_d  = out_src1_q;
      out_src2_d  = out_src2_q;
      out_err_d   = out_err_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (pop) begin
         out_valid_d = 1'b1;
         out_pc_d    = head.pc;
         out_instr_d = head.instr;
         out_dst_d   = head.instr[11:7];
         out_src1_d  = src1;
         out_src2_d  = src2;
         out_err_d   = err_code;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Queue storage needs no reset: nothing reads it while count is zero.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_pc_q    <= '0;
         out_instr_q <= '0;
         out_dst_q   <= '0;
         out_src1_q  <= '0;
         out_src2_q  <= '0;
         out_err_q   <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_pc_q    <= out_pc_d;
         out_instr_q <= out_instr_d;
         out_dst_q   <= out_dst_d;
         out_src1_q  <= out_src1_d;
         out_src2_q  <= out_src2_d;
         out_err_q   <= out_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pc    = out_pc_q;
   assign out_instr = out_instr_q;
   assign out_dst   = out_dst_q;
   assign out_src1  = out_src1_q;
   assign out_src2  = out_src2_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_decode_issue_queue.sv
module tb_decode_issue_queue;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned NFWD  = 3;

   logic                 clk, reset, flush;
   logic                 in_valid, in_ready;
   logic [63:0]          in_pc;
   logic [31:0]          in_instr;
   logic [1:0]           in_err;
   logic [4:0]           ra1, ra2;
   logic [XLEN-1:0]      rd1, rd2;
   logic [NFWD-1:0]      fwd_valid, fwd_pending;
   logic [NFWD*5-1:0]    fwd_dst;
   logic [NFWD*XLEN-1:0] fwd_data;
   logic                 stall_hazard, out_valid, out_ready;
   logic [63:0]          out_pc;
   logic [31:0]          out_instr;
   logic [4:0]           out_dst;
   logic [XLEN-1:0]      out_src1, out_src2;
   logic [1:0]           out_err;

   int n_checks = 0;
   int n_errors = 0;

   decode_issue_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NFWD(NFWD)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .in_err(in_err), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_pending(fwd_pending),
      .fwd_data(fwd_data), .stall_hazard(stall_hazard), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .out_dst(out_dst),
      .out_src1(out_src1), .out_src2(out_src2), .out_err(out_err)
   );

   // Register-file model: each register reads back a recognisable value.
   assign rd1 = 64'h1000 + {59'd0, ra1};
   assign rd2 = 64'h2000 + {59'd0, ra2};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [4:0] rd,
                                      input logic [6:0] op);
      return {f7, rs2, rs1, 3'b000, rd, op};
   endfunction

   task automatic push_one(input logic [63:0] pc, input logic [31:0] instr, input logic [1:0] err);
      in_valid = 1'b1;
      in_pc    = pc;
      in_instr = instr;
      in_err   = err;
      step();
      in_valid = 1'b0;
      in_err   = 2'd0;
   endtask

   localparam logic [6:0] OpR   = 7'b0110011;
   localparam logic [6:0] OpLui = 7'b0110111;

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_err = '0;
      fwd_valid = '0; fwd_dst = '0; fwd_pending = '0; fwd_data = '0; out_ready = 1'b1;
      step();
      step();
      reset = 1'b0;
      #1;
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_pc", out_pc, 0);
      check_eq("rst_out_src1", out_src1, 0);
      check_eq("rst_stall", stall_hazard, 0);

      // Stream four independent adds: out_valid from cycle 2, one per cycle, in order.
      for (int k = 0; k < 7; k++) begin
         in_valid = (k < 4);
         in_pc    = 64'h100 + 64'(4 * k);
         in_instr = mk(7'd0, 5'd2, 5'd1, 5'd3, OpR);
         #1;
         check_eq("stream_in_ready", in_ready, 1);
         if (k >= 2 && k < 6) begin
            check_eq("stream_valid", out_valid, 1);
            check_eq("stream_pc", out_pc, 64'h100 + 64'(4 * (k - 2)));
            check_eq("stream_src1", out_src1, 64'h1001);
            check_eq("stream_src2", out_src2, 64'h2002);
         end else begin
            check_eq("stream_idle", out_valid, 0);
         end
         step();
      end
      in_valid = 1'b0;

      // Forwarding priority: sources 1 and 2 both hit x5, source 1 is younger.
      fwd_valid = 3'b110;
      fwd_dst   = {5'd5, 5'd5, 5'd0};
      fwd_data  = {64'hBB, 64'hAA, 64'h0};
      push_one(64'h140, mk(7'd0, 5'd2, 5'd5, 5'd4, OpR), 2'd0);
      step();
      check_eq("fwd_valid", out_valid, 1);
      check_eq("fwd_src1", out_src1, 64'hAA);
      check_eq("fwd_src2_rf", out_src2, 64'h2002);
      step();
      // x0 reads zero even when a source claims to write x0.
      fwd_valid = 3'b111;
      fwd_dst   = '0;
      push_one(64'h144, mk(7'd0, 5'd2, 5'd0, 5'd4, OpR), 2'd0);
      step();
      check_eq("x0_src1", out_src1, 0);
      step();

      // Load-use hazard on x7 from EX.
      fwd_valid   = 3'b001;
      fwd_dst     = {5'd0, 5'd0, 5'd7};
      fwd_pending = 3'b001;
      fwd_data    = '0;
      push_one(64'h180, mk(7'h20, 5'd2, 5'd7, 5'd8, OpR), 2'd0);
      #1;
      check_eq("haz_stall0", stall_hazard, 1);
      for (int k = 0; k < 2; k++) begin
         step();
         check_eq("haz_stall", stall_hazard, 1);
         check_eq("haz_no_issue", out_valid, 0);
      end
      fwd_pending = 3'b000;
      fwd_data    = {64'h0, 64'h0, 64'h1234};
      #1;
      check_eq("haz_clear", stall_hazard, 0);
      step();
      check_eq("haz_issue", out_valid, 1);
      check_eq("haz_src1", out_src1, 64'h1234);
      check_eq("haz_pc", out_pc, 64'h180);
      check_eq("haz_dst", out_dst, 8);
      step();

      // Pending match on an unused rs1 field (LUI) and on faulting entries: no stall.
      fwd_pending = 3'b001;
      push_one(64'h1c0, mk(7'd0, 5'd0, 5'd7, 5'd9, OpLui), 2'd0);
      #1;
      check_eq("lui_no_stall", stall_hazard, 0);
      step();
      check_eq("lui_issue", out_valid, 1);
      check_eq("lui_err", out_err, 0);
      check_eq("lui_dst", out_dst, 9);
      step();
      push_one(64'h1c4, mk(7'd0, 5'd2, 5'd7, 5'd10, 7'b0000000), 2'd0);
      #1;
      check_eq("illegal_no_stall", stall_hazard, 0);
      step();
      check_eq("illegal_err", out_err, 3);
      step();
      push_one(64'h1c8, mk(7'd0, 5'd2, 5'd7, 5'd10, 7'b0000000), 2'd1);
      step();
      check_eq("fetch_err", out_err, 1);
      check_eq("fetch_err_pc", out_pc, 64'h1c8);
      step();
      fwd_valid = '0;
      fwd_pending = '0;

      // Backpressure with the queue full.
      out_ready = 1'b0;
      in_instr  = mk(7'd0, 5'd2, 5'd1, 5'd3, OpR);
      in_valid  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_pc = 64'h200 + 64'(4 * k);
         step();
      end
      in_valid = 1'b0;
      #1;
      check_eq("full_in_ready", in_ready, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("bp_valid", out_valid, 1);
         check_eq("bp_pc", out_pc, 64'h200);
         check_eq("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      #1;
      check_eq("pop_full_in_ready", in_ready, 0);
      step();
      check_eq("drain_pc1", out_pc, 64'h204);
      check_eq("drain_in_ready", in_ready, 1);
      step();
      check_eq("drain_pc2", out_pc, 64'h208);
      check_eq("drain_valid2", out_valid, 1);
      step();
      check_eq("drain_empty", out_valid, 0);

      // Flush with an entry in the output stage, one queued, and a push offered.
      out_ready = 1'b0;
      push_one(64'h300, mk(7'd0, 5'd2, 5'd1, 5'd3, OpR), 2'd0);
      push_one(64'h304, mk(7'd0, 5'd2, 5'd1, 5'd3, OpR), 2'd0);
      check_eq("pre_flush_valid", out_valid, 1);
      in_valid = 1'b1;
      in_pc    = 64'h308;
      flush    = 1'b1;
      #1;
      check_eq("flush_stall", stall_hazard, 0);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      check_eq("flush_out_valid", out_valid, 0);
      check_eq("flush_in_ready", in_ready, 1);
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("flush_no_ghost", out_valid, 0);
      end

      // Reset mid-operation clears the output stage including data.
      out_ready = 1'b0;
      push_one(64'h400, mk(7'd0, 5'd2, 5'd1, 5'd3, OpR), 2'd0);
      step();
      check_eq("pre_rst_pc", out_pc, 64'h400);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check_eq("mid_rst_valid", out_valid, 0);
      check_eq("mid_rst_pc", out_pc, 0);
      check_eq("mid_rst_src1", out_src1, 0);
      check_eq("mid_rst_in_ready", in_ready, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
